// File: rtl/vt52_pkg.sv
// Shared VT52 terminal definitions: screen geometry, control codes and the
// character writer state encoding. The CLEAR_ALL state exists only when
// FF_CLEAR_EN is defined.
package vt52_pkg;

  localparam int unsigned COLS   = 64;
  localparam int unsigned ROWS   = 16;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned ADDR_W = ROW_W + COL_W;
  localparam int unsigned CNT_W  = 10;

  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

`ifdef FF_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_CLEAR_ALL} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR} state_t;
`endif

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/char_writer_if.sv
// Character input handshake plus character buffer write port.
// master: character source / bench side; slave: the char_writer itself.
interface char_writer_if;
  import vt52_pkg::*;

  logic [7:0]        in_char;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_din;
  logic              buf_we;

  modport master (
    output in_char, in_valid,
    input  in_ready, buf_waddr, buf_din, buf_we
  );

  modport slave (
    input  in_char, in_valid,
    output in_ready, buf_waddr, buf_din, buf_we
  );
endinterface

// File: rtl/char_writer.sv
// VT52-style character writer: places printable characters at the cursor,
// handles BS/CR/LF, auto-wraps, and scrolls by advancing first_row and
// clearing the newly exposed row. Optional macro FF_CLEAR_EN adds a
// form-feed full-screen clear (CLEAR_ALL state).
module char_writer
  import vt52_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             rst_n,
  char_writer_if.slave     bus,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] first_row,
  output logic             busy
);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        din_q, din_d;
  logic              do_lf;

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.buf_we    = we_q;
  assign bus.buf_waddr = waddr_q;
  assign bus.buf_din   = din_q;
  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
  assign first_row     = first_q;
  assign busy          = (state_q != ST_IDLE);

  // Next-state, cursor update and registered buffer-write computation.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
    do_lf   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_printable(bus.in_char)) begin
            we_d    = 1'b1;
            din_d   = bus.in_char;
            waddr_d = {first_q + row_q, col_q};
            if (col_q == COL_W'(COLS - 1)) begin
              col_d = '0;
              do_lf = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (bus.in_char == CH_LF) begin
            do_lf = 1'b1;
          end else if (bus.in_char == CH_CR) begin
            col_d = '0;
          end else if (bus.in_char == CH_BS) begin
            if (col_q != '0) col_d = col_q - COL_W'(1);
`ifdef FF_CLEAR_EN
          end else if (bus.in_char == CH_FF) begin
            row_d   = '0;
            col_d   = '0;
            first_d = '0;
            cnt_d   = '0;
            state_d = ST_CLEAR_ALL;
`endif
          end
          // Scroll: the clear targets the row that becomes the new bottom,
          // i.e. new first_row + 15, which is the old top row.
          if (do_lf) begin
            if (row_q != ROW_W'(ROWS - 1)) begin
              row_d = row_q + ROW_W'(1);
            end else begin
              first_d = first_q + ROW_W'(1);
              cnt_d   = '0;
              state_d = ST_CLEAR;
            end
          end
        end
      end
      ST_CLEAR: begin
        we_d    = 1'b1;
        din_d   = CLEAR_CHAR;
        waddr_d = {first_q + ROW_W'(ROWS - 1), cnt_q[COL_W-1:0]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q[COL_W-1:0] == COL_W'(COLS - 1)) state_d = ST_IDLE;
      end
`ifdef FF_CLEAR_EN
      ST_CLEAR_ALL: begin
        we_d    = 1'b1;
        din_d   = CLEAR_CHAR;
        waddr_d = cnt_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == '1) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      first_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: tb/tb_char_writer.sv
// Self-checking bench for char_writer: a timeline-based reference model
// (cursor arithmetic plus a queue of timestamped buffer writes) checked every
// cycle, with directed scenarios and a randomized character stream.
// Honours FF_CLEAR_EN the same way the design does.
module tb_char_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic [3:0] first_row;
  logic       busy;

  char_writer_if bus ();

  char_writer #(.CLEAR_CHAR(8'h20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .first_row  (first_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  n = 0;
  int  busy_last = -1;
  int  m_row = 0, m_col = 0, m_first = 0;
  bit  m_valid = 0, m_bus_rst = 0;
  bit  m_we = 0;
  int  m_addr = 0, m_din = 0;

  always @(posedge clk) begin
    int ch;
    bit lf;
    n++;
    if (!rst_n) begin
      m_row = 0; m_col = 0; m_first = 0;
      busy_last = -1;
      wq.delete();
      m_we = 0; m_addr = 0; m_din = 0;
      m_valid = 1; m_bus_rst = 1;
    end else if (m_valid) begin
      m_bus_rst = 0;
      if (bus.in_valid && !(n - 1 <= busy_last)) begin
        ch = int'(bus.in_char);
        lf = 0;
        if (ch >= 32 && ch <= 126) begin
          wq.push_back('{n, ((m_first + m_row) % 16) * 64 + m_col, ch});
          if (m_col == 63) begin m_col = 0; lf = 1; end
          else m_col = m_col + 1;
        end else if (ch == 10) lf = 1;
        else if (ch == 13) m_col = 0;
        else if (ch == 8) begin if (m_col > 0) m_col = m_col - 1; end
`ifdef FF_CLEAR_EN
        else if (ch == 12) begin
          m_row = 0; m_col = 0; m_first = 0;
          busy_last = n + 1023;
          for (int i = 0; i < 1024; i++) wq.push_back('{n + 1 + i, i, 32});
        end
`endif
        if (lf) begin
          if (m_row < 15) m_row = m_row + 1;
          else begin
            m_first = (m_first + 1) % 16;
            busy_last = n + 63;
            for (int i = 0; i < 64; i++)
              wq.push_back('{n + 1 + i, ((m_first + 15) % 16) * 64 + i, 32});
          end
        end
      end
      if (wq.size() > 0 && wq[0].cyc == n) begin
        m_we = 1; m_addr = wq[0].addr; m_din = wq[0].data;
        void'(wq.pop_front());
      end else begin
        m_we = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("buf_we", bus.buf_we, m_we);
      if (m_we || m_bus_rst) begin
        chk("buf_waddr", bus.buf_waddr, m_addr);
        chk("buf_din", bus.buf_din, m_din);
      end
      chk("cursor_row", cursor_row, m_row);
      chk("cursor_col", cursor_col, m_col);
      chk("first_row", first_row, m_first);
      chk("busy", busy, (n <= busy_last));
      chk("in_ready", bus.in_ready, !(n <= busy_last));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called just after a negedge; returns at the negedge following the handshake.
  task automatic send(input logic [7:0] ch);
    int k = 0;
    while (!bus.in_ready && k < 3000) begin @(negedge clk); k++; end
    if (!bus.in_ready) begin
      chk("send_ready_timeout", 0, 1);
    end else begin
      bus.in_char = ch;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_char = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 99);
    if (r < 62) return 8'($urandom_range(32, 126));
    if (r < 74) return 8'h0A;
    if (r < 82) return 8'h0D;
    if (r < 90) return 8'h08;
    if (r < 92) return 8'h0C;
    if ($urandom_range(0, 1) == 1) return 8'($urandom_range(0, 31));
    return 8'($urandom_range(127, 255));
  endfunction

  // ---------------- directed + random scenarios ----------------
  initial begin
    int bc, wc;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_we", bus.buf_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_col", cursor_col, 0);

    // single printable character
    send(8'h41);
    chk("A_we", bus.buf_we, 1);
    chk("A_addr", bus.buf_waddr, 10'h000);
    chk("A_din", bus.buf_din, 8'h41);
    chk("A_col", cursor_col, 1);

    // 64 chars from 0,0 wrap to row 1 without scrolling
    do_reset();
    for (int i = 0; i < 64; i++) begin
      send(8'h42);
      if (i == 63) chk("wrap_last_addr", bus.buf_waddr, 10'd63);
    end
    chk("wrap_row", cursor_row, 1);
    chk("wrap_col", cursor_col, 0);
    chk("wrap_first", first_row, 0);

    // BS at col 0, CR at col 10
    do_reset();
    send(8'h08);
    chk("bs0_col", cursor_col, 0);
    chk("bs0_we", bus.buf_we, 0);
    for (int i = 0; i < 10; i++) send(8'h61);
    chk("pre_cr_col", cursor_col, 10);
    send(8'h0D);
    chk("cr_col", cursor_col, 0);
    chk("cr_we", bus.buf_we, 0);

    // scroll from row 15 col 5
    do_reset();
    for (int i = 0; i < 15; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h78);
    send(8'h0A);
    chk("scr_first", first_row, 1);
    chk("scr_row", cursor_row, 15);
    chk("scr_col", cursor_col, 5);
    bc = 0; wc = 0;
    for (int i = 0; i < 70; i++) begin
      if (busy) begin
        bc++;
        chk("scr_ready_low", bus.in_ready, 0);
      end
      if (bus.buf_we) begin
        chk("scr_addr", bus.buf_waddr, wc);
        chk("scr_din", bus.buf_din, 8'h20);
        wc++;
      end
      @(negedge clk);
    end
    chk("scr_busy_cycles", bc, 64);
    chk("scr_writes", wc, 64);

    // reset in the middle of a clear aborts it
    send(8'h0A);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_we", bus.buf_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_first", first_row, 0);
    chk("abort_row", cursor_row, 0);
    chk("abort_addr", bus.buf_waddr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // form feed with first_row = 3
    do_reset();
    for (int i = 0; i < 18; i++) send(8'h0A);
    wait_idle();
    chk("ff_pre_first", first_row, 3);
    send(8'h0C);
`ifdef FF_CLEAR_EN
    chk("ff_busy", busy, 1);
    chk("ff_first", first_row, 0);
    chk("ff_row", cursor_row, 0);
    wait_idle();
    chk("ff_done_col", cursor_col, 0);
`else
    chk("ff_busy", busy, 0);
    chk("ff_we", bus.buf_we, 0);
    chk("ff_first", first_row, 3);
    chk("ff_row", cursor_row, 15);
`endif

    // randomized stream
    do_reset();
    for (int i = 0; i < 800; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 199) == 0) do_reset();
      send(pick());
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_writer.md
CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 Parameter CLEAR_CHAR, default 8'h20, is the code written into cleared cells.
REQ-002 clk  input  1  is the single clock; all logic is clocked on its rising edge.
REQ-003 rst_n  input  1  is the reset: synchronous and active-low.
REQ-004 in_char  input  8  is the incoming character code.
REQ-005 in_valid  input  1  indicates in_char is valid.
REQ-006 in_ready  output  1  indicates the block accepts in_char this cycle.
REQ-007 buf_waddr  output  10  is the char buffer write address {phys_row[3:0], col[5:0]}.
REQ-008 buf_din  output  8  is the char buffer write data.
REQ-009 buf_we  output  1  is the char buffer write enable.
REQ-010 cursor_row  output  4  is the logical cursor row (0 = top of screen).
REQ-011 cursor_col  output  6  is the cursor column.
REQ-012 first_row  output  4  is the physical buffer row shown at screen top; the scan-out side adds it mod 16.
REQ-013 busy  output  1  is high while a clear sequence runs.

Function
REQ-014 The block SHALL use states IDLE and CLEAR, plus CLEAR_ALL when FF_CLEAR_EN is defined; in_ready SHALL be 1 only in IDLE.
REQ-015 A handshake occurs when in_valid and in_ready are both 1; in_char SHALL be sampled only then.
REQ-016 Printable codes 8'h20..8'h7E SHALL produce buf_we=1 on the next cycle, with buf_din=in_char and buf_waddr={first_row+cursor_row mod 16, cursor_col}, using the pre-handshake values.
REQ-017 After a printable write at cursor_col<63, cursor_col SHALL increment by 1.
REQ-018 After a printable write at cursor_col=63, cursor_col SHALL become 0 and a line feed SHALL be performed (auto-wrap).
REQ-019 Line feed (8'h0A or auto-wrap) with cursor_row<15 SHALL increment cursor_row by 1.
REQ-020 Line feed at cursor_row=15 SHALL leave cursor_row unchanged, increment first_row mod 16, and enter CLEAR.
REQ-021 CR (8'h0D) SHALL set cursor_col to 0.
REQ-022 BS (8'h08) SHALL decrement cursor_col when it is >0, and do nothing at 0.
REQ-023 All other codes SHALL be consumed with no write and no cursor change.
REQ-024 In CLEAR the block SHALL issue 64 consecutive writes of CLEAR_CHAR to phys row (new first_row+15 mod 16), cols 0..63 ascending, then return to IDLE on the following cycle.
REQ-025 busy SHALL be 1 exactly while the state is not IDLE.
REQ-026 buf_we SHALL be 0 in every cycle that carries no write; buf_din and buf_waddr are don't-care when buf_we=0.
REQ-027 In the wrap-plus-scroll case, the character write SHALL precede the first clear write, and the character is never overwritten.

Reset
REQ-028 When rst_n=0 at a clock edge, on the next cycle: state=IDLE, cursor_row=0, cursor_col=0, first_row=0, buf_we=0, buf_waddr=0, buf_din=0, busy=0.
REQ-029 Reset during CLEAR or CLEAR_ALL SHALL abort the sequence, with no further writes.
REQ-030 Reset SHALL NOT clear the buffer; its contents come from the RAM init file.

Configuration
REQ-031 Macro FF_CLEAR_EN defined: FF (8'h0C) SHALL set the cursor to 0,0 and first_row to 0, then write CLEAR_CHAR to all addresses 0..1023 ascending (1024 cycles, busy=1), then return to IDLE.
REQ-032 Macro FF_CLEAR_EN undefined: 8'h0C SHALL be ignored per REQ-023, and the CLEAR_ALL state SHALL NOT exist.

Structure
REQ-033 Shared package vt52_pkg SHALL hold COLS=64, ROWS=16, the row/col/address widths, the control codes (BS, LF, CR, FF), and the state enum.
REQ-034 The block SHALL be a single module, with the clear counter (10 bits, 6 used for CLEAR) inline; no sub-module is required.

Verification
REQ-035 After reset, send "A" (8'h41) -> one cycle later buf_we=1, buf_waddr=0, buf_din=8'h41; cursor_col=1.
REQ-036 Send 64 x 8'h42 from 0,0 -> last write at addr 63; then cursor_row=1, cursor_col=0, first_row=0.
REQ-037 With cursor at row 15 col 5, send LF -> first_row=1, busy=1 for 64 cycles writing 8'h20 to addrs 0..63, in_ready=0 throughout, cursor_row=15, cursor_col=5.
REQ-038 Send BS at col 0, then CR at col 10 -> col stays 0, then col becomes 0; no buf_we pulses.
REQ-039 Assert rst_n=0 at cycle 20 of a CLEAR -> next cycle buf_we=0, busy=0, all outputs at reset values.
REQ-040 With FF_CLEAR_EN, send 8'h0C with first_row=3 -> 1024 writes of 8'h20 to addrs 0..1023, then first_row=0 and cursor at 0,0; without FF_CLEAR_EN, no writes and no state change.
